sram_reader: RTL and testbench

//  Read initiator for the single-port synchronous-read SRAM banks (SRAM_n) feeding the MAC.
//  On a start command, fetches LEN consecutive words starting at BASE_ADDR.

---
 rtl/sram_reader_pkg.sv | 23 ++
 rtl/sram_reader_if.sv | 34 +++
 rtl/sram_reader_skid.sv | 63 ++++++
 rtl/sram_reader.sv | 129 ++++++++++++
 tb/tb_sram_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_reader_pkg.sv
// Shared types and defaults for the SRAM burst reader.
package sram_reader_pkg;

    // Default word width of the SRAM Dout bus.
    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Skid buffer occupancy (0..2).
    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Reads outstanding after this cycle: buffered + in flight - leaving now.
    function automatic logic [2:0] pending(input occ_t occ, input logic inflight,
                                           input logic pop);
        return 3'(occ) + 3'(inflight) - 3'(pop);
    endfunction

endpackage

// File: rtl/sram_reader_if.sv
// Command, SRAM and output-stream signals of the SRAM burst reader.
interface sram_reader_if
    import sram_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 5
);
    // command side
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  done;
    // SRAM side
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_en;
    logic [DATA_WIDTH-1:0] sram_dout;
    // output stream
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  start, base_addr, len, sram_dout, m_ready,
        output busy, done, sram_addr, sram_en, m_valid, m_data
    );

    modport slave (
        output start, base_addr, len, sram_dout, m_ready,
        input  busy, done, sram_addr, sram_en, m_valid, m_data
    );

endinterface

// File: rtl/sram_reader_skid.sv
// 2-entry synchronous FIFO that catches SRAM read data and presents a
// registered head word to the output stream.
module sram_rd_skid
    import sram_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  do_pop;
    logic                  do_push;

    // Qualify pop/push against the current fill level.
    always_comb begin
        do_pop  = pop && (occ != 2'd0);
        do_push = push && ((occ != 2'd2) || do_pop);
    end

    // Entry 0 is always the head; entry 1 shifts into it on a pop.
    always_ff @(posedge clk) begin
        if (flush) begin
            occ    <= '0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0;

endmodule

// File: rtl/sram_reader.sv
// Burst read initiator: fetches len consecutive SRAM words from base_addr,
// absorbs the one-cycle read latency and streams them out over valid/ready.
module sram_reader
    import sram_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 5
) (
    input logic         clk,
    input logic         rst_n,
    sram_reader_if.master bus
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  accepted;
    logic                  inflight_q;
    logic                  issue;
    logic                  xfer;
    logic                  accept_start;
    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;

    // Read issue: only in RUN, only while words remain, and only when the
    // buffer can still take every read that is outstanding after this cycle.
    always_comb begin
        xfer         = (occ != 2'd0) && bus.m_ready;
        accept_start = (state == S_IDLE) && bus.start;
        issue_addr   = base_q + ADDR_WIDTH'(issued);
        issue        = (state == S_RUN) && (issued != len_q)
                       && (pending(occ, inflight_q, xfer) < 3'd2);
    end

    // Next-state logic and command/SRAM outputs.
    always_comb begin
        state_nxt     = state;
        bus.busy      = (state == S_RUN) || (state == S_DRAIN);
        bus.done      = (state == S_FIN);
        bus.sram_en   = issue;
        bus.sram_addr = issue ? issue_addr : last_addr_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.len == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && ((issued + LEN_WIDTH'(1)) == len_q)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // leave on the cycle of the final transfer so done follows it directly
                if ((accepted == len_q) || (xfer && ((accepted + LEN_WIDTH'(1)) == len_q))) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture, issue/accept counters and the in-flight read flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            accepted    <= '0;
            inflight_q  <= 1'b0;
            last_addr_q <= '0;
        end else begin
            inflight_q <= issue;
            if (accept_start) begin
                base_q   <= bus.base_addr;
                len_q    <= bus.len;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (issue) begin
                    issued      <= issued + LEN_WIDTH'(1);
                    last_addr_q <= issue_addr;
                end
                if (xfer) begin
                    accepted <= accepted + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Read data lands in the skid buffer the cycle after the read is issued.
    sram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .flush (!rst_n),
        .push  (inflight_q),
        .din   (bus.sram_dout),
        .pop   (xfer),
        .occ   (occ),
        .head  (head)
    );

    // Output stream driven straight from buffer registers.
    always_comb begin
        bus.m_valid = (occ != 2'd0);
        bus.m_data  = head;
    end

endmodule

// File: tb/tb_sram_reader.sv
// Randomized self-checking bench for sram_reader with a behavioural SRAM and
// a word-queue reference model.
module tb_sram_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(5)) bus ();

    sram_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // synchronous-read SRAM model
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.sram_en) bus.sram_dout <= mem[bus.sram_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference state for the current burst
    logic [7:0] exp_q [$];
    bit   active = 1'b0;
    int   start_cyc, cur_base, cur_len;
    int   n_issue, n_xfer, n_done;
    int   first_valid_cyc, last_xfer_cyc;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data;

    // monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", int'(bus.m_valid), 1);
                chk("hold_data", int'(bus.m_data), int'(prev_data));
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (active && cyc > start_cyc) begin
                if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.sram_en) begin
                    chk("issue_addr", int'(bus.sram_addr), (cur_base + n_issue) % 16);
                    n_issue++;
                    chk("issue_count", int'(n_issue <= cur_len), 1);
                end
                if (bus.m_valid && bus.m_ready) begin
                    chk("word_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("word", int'(bus.m_data), int'(exp_q.pop_front()));
                    n_xfer++;
                    last_xfer_cyc = cyc;
                end
                chk("outstanding", int'((n_issue - n_xfer) <= 2), 1);
                if (bus.done) begin
                    n_done++;
                    chk("done_busy", int'(bus.busy), 0);
                    chk("done_xfers", n_xfer, cur_len);
                    if (cur_len != 0) chk("done_latency", cyc - last_xfer_cyc, 1);
                    else chk("done_latency_len0", cyc - start_cyc, 1);
                    active = 1'b0;
                end else begin
                    chk("busy", int'(bus.busy), 1);
                end
            end else if (!active) begin
                chk("idle_busy", int'(bus.busy), 0);
                chk("idle_done", int'(bus.done), 0);
                chk("idle_en", int'(bus.sram_en), 0);
                chk("idle_valid", int'(bus.m_valid), 0);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready high, 1 toggling, 2 stalled 10 cycles, 3 random
    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return (k % 2) == 0;
            2: return k > 10;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic launch(input int base, input int len, input int mode);
        bus.start     = 1'b1;
        bus.base_addr = 4'(base);
        bus.len       = 5'(len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[4'(base + i)]);
        n_issue = 0; n_xfer = 0; n_done = 0;
        first_valid_cyc = -1; last_xfer_cyc = -1;
        start_cyc = cyc; cur_base = base; cur_len = len;
        active = 1'b1;
        bus.m_ready = ready_for(mode, 0);
    endtask

    // inject=1 re-asserts start during RUN and during FIN (mode 0 only)
    task automatic burst(input int base, input int len, input int mode, input bit inject);
        int k;
        launch(base, len, mode);
        k = 0;
        while (active && k < 300) begin
            tick();
            k++;
            bus.start = inject && (k == 2 || k == len + 3);
            if (bus.start) begin
                bus.base_addr = 4'($urandom_range(0, 15));
                bus.len       = 5'($urandom_range(1, 16));
            end
            if (mode == 2 && k == 11) chk("stall_issues", int'(n_issue <= 2), 1);
            bus.m_ready = ready_for(mode, k);
        end
        bus.start = 1'b0;
        chk("burst_timeout", int'(active), 0);
        if (len != 0) chk("first_valid", first_valid_cyc - start_cyc, 3);
        if (mode == 0 && len != 0) chk("stream_gapless", last_xfer_cyc - first_valid_cyc, len - 1);
        repeat (3) begin
            bus.m_ready = $urandom_range(0, 1) != 0;
            tick();
        end
        chk("done_once", n_done, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_en"}, int'(bus.sram_en), 0);
        chk({tag, "_addr"}, int'(bus.sram_addr), 0);
        chk({tag, "_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_data"}, int'(bus.m_data), 0);
    endtask

    initial begin
        int k;
        mem[0] = 8'd3; mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd6; mem[4] = 8'd0;
        mem[5] = 8'd5; mem[6] = 8'd0; mem[7] = 8'd0; mem[8] = 8'd3;
        for (int i = 9; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        burst(0, 9, 0, 1'b0);
        burst(2, 4, 1, 1'b0);
        burst(5, 3, 2, 1'b0);
        burst(0, 0, 0, 1'b0);

        // reset after the second transfer of a full burst
        launch(0, 9, 0);
        k = 0;
        while (n_xfer < 2 && k < 20) begin
            tick();
            k++;
            bus.start = 1'b0;
        end
        chk("abort_reached", n_xfer, 2);
        rst_n = 1'b0;
        active = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check_zero_outputs("abort");
        repeat (4) tick();
        burst(3, 2, 0, 1'b0);

        burst(1, 6, 0, 1'b1);
        burst(7, 1, 0, 1'b1);

        repeat (14) begin
            burst($urandom_range(0, 15), $urandom_range(0, 16), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
